// File: rtl/wb_arbiter_if.sv
// Bus bundle for the writeback arbiter.
// Producer side: alu_* and mem_* valid/ready handshakes carrying a destination
// register and a result. Register-file side: we3/wa3/wd3 single write port,
// plus the busy mask used by issue logic for hazard detection.
//   master : producers / register file (drive valid, rd, data; observe the rest)
//   slave  : the arbiter itself
interface wb_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic                alu_valid;
    logic                alu_ready;
    logic [AW-1:0]       alu_rd;
    logic [WIDTH-1:0]    alu_data;
    logic                mem_valid;
    logic                mem_ready;
    logic [AW-1:0]       mem_rd;
    logic [WIDTH-1:0]    mem_data;
    logic                we3;
    logic [AW-1:0]       wa3;
    logic [WIDTH-1:0]    wd3;
    logic [2**AW-1:0]    busy;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  alu_ready, mem_ready,
        input  we3, wa3, wd3, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output alu_ready, mem_ready,
        output we3, wa3, wd3, busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding the register file's single write port.
// Two producers (ALU results and memory loads) each fill a private FIFO through
// a valid/ready handshake. Every cycle one FIFO head is chosen round-robin and
// registered onto we3/wa3/wd3. A per-register busy mask reports every write
// still queued or currently on the write port.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      wb_arbiter_if.slave: alu_*/mem_* handshakes, we3/wa3/wd3, busy
module wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_arbiter_if.slave bus
);
    localparam int            NREGS = 2**AW;
    localparam int            PW    = $clog2(DEPTH);
    localparam int            CW    = PW + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam int            ALU   = 0;
    localparam int            MEM   = 1;

    typedef enum logic {
        PREF_ALU = 1'b0,
        PREF_MEM = 1'b1
    } rr_e;

    // FIFO state, indexed by source (ALU / MEM)
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];
    logic [AW-1:0]    ent_rd_q   [2][DEPTH];
    logic [WIDTH-1:0] ent_data_q [2][DEPTH];

    rr_e              rr_q, rr_d;
    logic             en_q;

    logic             we_q, we_d;
    logic [AW-1:0]    wa_q, wa_d;
    logic [WIDTH-1:0] wd_q, wd_d;

    logic [1:0]       in_valid;
    logic [AW-1:0]    in_rd   [2];
    logic [WIDTH-1:0] in_data [2];
    logic [1:0]       ready;
    logic [1:0]       push;
    logic [1:0]       nonempty;
    logic [1:0]       gnt;
    logic             src;
    logic [NREGS-1:0] busy_c;

    assign in_valid    = {bus.mem_valid, bus.alu_valid};
    assign in_rd[ALU]  = bus.alu_rd;
    assign in_rd[MEM]  = bus.mem_rd;
    assign in_data[ALU] = bus.alu_data;
    assign in_data[MEM] = bus.mem_data;

    // Handshake and arbitration: everything here depends only on registered
    // state (plus valid for the push decision), so ready has no path from
    // valid or from the output stage.
    always_comb begin
        ready    = '0;
        push     = '0;
        nonempty = '0;
        gnt      = '0;
        rr_d     = rr_q;
        src      = 1'b0;
        we_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        for (int s = 0; s < 2; s++) begin
            nonempty[s] = (cnt_q[s] != '0);
            // en_q keeps both inputs closed until the first edge after reset.
            // A full FIFO refuses even when it pops this edge.
            ready[s]    = en_q && (cnt_q[s] < FULL);
            push[s]     = in_valid[s] && ready[s];
        end

        if (nonempty[ALU] && (!nonempty[MEM] || rr_q == PREF_ALU)) begin
            gnt[ALU] = 1'b1;
            rr_d     = PREF_MEM;
        end else if (nonempty[MEM]) begin
            gnt[MEM] = 1'b1;
            rr_d     = PREF_ALU;
        end

        if (gnt != '0) begin
            src  = gnt[MEM];
            // Register 0 still takes its output slot, just without a write.
            we_d = (ent_rd_q[src][rd_ptr_q[src]] != '0);
            wa_d = ent_rd_q[src][rd_ptr_q[src]];
            wd_d = ent_data_q[src][rd_ptr_q[src]];
        end

        for (int s = 0; s < 2; s++) begin
            wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PW'(gnt[s]);
            cnt_d[s]    = cnt_q[s] + CW'(push[s]) - CW'(gnt[s]);
        end
    end

    // Pending-write mask: live FIFO slots of both sources plus the write
    // currently on the port.
    always_comb begin
        logic [PW-1:0] off;
        off    = '0;
        busy_c = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                // Slot i is live when its distance from the read pointer is
                // below the occupancy count.
                off = PW'(i) - rd_ptr_q[s];
                if ({1'b0, off} < cnt_q[s]) begin
                    busy_c[ent_rd_q[s][i]] = 1'b1;
                end
            end
        end
        if (we_q) begin
            busy_c[wa_q] = 1'b1;
        end
        busy_c[0] = 1'b0;
    end

    // ---- Stage boundary: FIFO control, RR pointer, output register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            rr_q <= PREF_ALU;
            en_q <= 1'b0;
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                cnt_q[s]    <= cnt_d[s];
            end
            rr_q <= rr_d;
            en_q <= 1'b1;
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
        end
    end

    // FIFO storage carries data only; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                ent_rd_q[s][wr_ptr_q[s]]   <= in_rd[s];
                ent_data_q[s][wr_ptr_q[s]] <= in_data[s];
            end
        end
    end

    assign bus.alu_ready = ready[ALU];
    assign bus.mem_ready = ready[MEM];
    assign bus.we3       = we_q;
    assign bus.wa3       = wa_q;
    assign bus.wd3       = wd_q;
    assign bus.busy      = busy_c;
endmodule
